// File: rtl/fetch_unit.sv
// Instruction fetch / program-counter block: one imem read per instruction, issue to decode, then wait for resolved NPC.
// Optional FETCH_HALT_EN: opcode 6'b111111 parks the fetch in HALTED until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  input  logic [31:0] NPC,
  input  logic        npc_valid
`ifdef FETCH_HALT_EN
  ,
  output logic        halted
`endif
);

  localparam int unsigned XLEN = 32;

`ifdef FETCH_HALT_EN
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_NPC = 3'd3,
    S_HALTED   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_ISSUE    = 2'd2,
    S_WAIT_NPC = 2'd3
  } state_t;
`endif

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_pc_plus_4;
  logic [XLEN-1:0]   r_ir;
  logic              r_imem_req;
  logic              r_ir_valid;
  logic [XLEN-1:0]   w_npc_aligned;
`ifdef FETCH_HALT_EN
  logic              r_halted;
  logic              w_halt_op;
  assign w_halt_op = (r_ir[31:26] == 6'b111111);
`endif

  // Branch targets are word aligned; stray low bits are dropped.
  assign w_npc_aligned = NPC & ~XLEN'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_pc_plus_4 <= RESET_PC + XLEN'(4);
      r_ir        <= '0;
      r_imem_req  <= 1'b0;
      r_ir_valid  <= 1'b0;
`ifdef FETCH_HALT_EN
      r_halted    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_state    <= S_ISSUE;
            r_imem_req <= 1'b0;
            r_ir_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (ir_ready) begin
            r_ir_valid <= 1'b0;
`ifdef FETCH_HALT_EN
            if (w_halt_op) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state  <= S_WAIT_NPC;
            end
`else
            r_state    <= S_WAIT_NPC;
`endif
          end
        end
        S_WAIT_NPC: begin
          if (npc_valid) begin
            r_pc        <= w_npc_aligned;
            r_pc_plus_4 <= w_npc_aligned + XLEN'(4);
            r_state     <= S_FETCH;
            r_imem_req  <= 1'b1;
          end
        end
`ifdef FETCH_HALT_EN
        S_HALTED: begin
          r_state <= S_HALTED;
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
          r_ir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign ir_valid  = r_ir_valid;
  assign IR        = r_ir;
  assign PC        = r_pc;
  assign PC_plus_4 = r_pc_plus_4;
`ifdef FETCH_HALT_EN
  assign halted    = r_halted;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level PC/IR model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] IR;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;
  logic [31:0] NPC = '0;
  logic        npc_valid = 1'b0;
`ifdef FETCH_HALT_EN
  logic        halted;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_pc;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready),
    .IR(IR), .PC(PC), .PC_plus_4(PC_plus_4),
    .NPC(NPC), .npc_valid(npc_valid)
`ifdef FETCH_HALT_EN
    , .halted(halted)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
`ifdef FETCH_HALT_EN
    if (w[31:26] == 6'b111111) w[26] = 1'b0;
`endif
    return w;
  endfunction

  // FETCH with d wait cycles, then ISSUE held for stall cycles, then handshake.
  task automatic fetch_and_issue(input logic [31:0] word, input int d, input int stall);
    for (int i = 0; i < d; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        npc_valid = 1'b1;
        NPC       = $urandom;
      end
      ir_ready = 1'($urandom_range(0, 1));
      tick();
      npc_valid = 1'b0;
      ir_ready  = 1'b0;
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", imem_addr, exp_pc);
      check("no_valid_in_fetch", 32'(ir_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("issue_valid", 32'(ir_valid), 32'd1);
    check("issue_ir", IR, word);
    check("issue_pc", PC, exp_pc);
    check("issue_pc4", PC_plus_4, exp_pc + 32'd4);
    check("issue_req_low", 32'(imem_req), 32'd0);
    for (int i = 0; i < stall; i++) begin
      ir_ready = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        npc_valid = 1'b1;
        NPC       = $urandom;
      end
      tick();
      imem_ack  = 1'b0;
      npc_valid = 1'b0;
      check("stall_valid", 32'(ir_valid), 32'd1);
      check("stall_ir", IR, word);
      check("stall_pc", PC, exp_pc);
      check("stall_req_low", 32'(imem_req), 32'd0);
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("accept_valid_low", 32'(ir_valid), 32'd0);
    check("accept_req_low", 32'(imem_req), 32'd0);
  endtask

  // WAIT_NPC for wait_n idle cycles, then deliver npc; model PC is npc rounded down to a word.
  task automatic redirect(input logic [31:0] npc, input int wait_n);
    for (int i = 0; i < wait_n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
      end
      ir_ready = 1'($urandom_range(0, 1));
      tick();
      imem_ack = 1'b0;
      ir_ready = 1'b0;
      check("wait_req_low", 32'(imem_req), 32'd0);
      check("wait_valid_low", 32'(ir_valid), 32'd0);
      check("wait_pc", PC, exp_pc);
    end
    npc_valid = 1'b1;
    NPC       = npc;
    tick();
    npc_valid = 1'b0;
    NPC       = $urandom;
    exp_pc    = npc - (npc % 32'd4);
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_addr", imem_addr, exp_pc);
    check("refetch_pc", PC, exp_pc);
    check("refetch_pc4", PC_plus_4, exp_pc + 32'd4);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_ir", IR, 32'd0);
    check("rst_pc", PC, RST_PC);
    check("rst_pc4", PC_plus_4, RST_PC + 32'd4);
`ifdef FETCH_HALT_EN
    check("rst_halted", 32'(halted), 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    exp_pc = RST_PC;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RST_PC);

    fetch_and_issue(32'h1234_5678, 0, 0);
    redirect(32'h0000_0203, 1);
    fetch_and_issue(rand_word(), 3, 5);
    redirect(32'hFFFF_FFFC, 0);
    fetch_and_issue(rand_word(), 0, 0);
    redirect(32'h0000_0000, 0);
`ifndef FETCH_HALT_EN
    fetch_and_issue(32'hFC00_0000, 1, 1);
    redirect(32'h0000_0040, 2);
`endif

    for (int n = 0; n < 40; n++) begin
      fetch_and_issue(rand_word(), $urandom_range(0, 3), $urandom_range(0, 3));
      redirect($urandom, $urandom_range(0, 3));
    end

    // Reset while a request is outstanding.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_pc", PC, RST_PC);
    check("midrst_valid", 32'(ir_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    exp_pc = RST_PC;
    check("midrst_refetch_req", 32'(imem_req), 32'd1);
    check("midrst_refetch_addr", imem_addr, RST_PC);

`ifdef FETCH_HALT_EN
    fetch_and_issue(32'hFC00_0000, 0, 0);
    check("halt_set", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      npc_valid  = 1'($urandom_range(0, 1));
      NPC        = $urandom;
      imem_ack   = 1'($urandom_range(0, 1));
      ir_ready   = 1'($urandom_range(0, 1));
      tick();
      check("halt_req_low", 32'(imem_req), 32'd0);
      check("halt_valid_low", 32'(ir_valid), 32'd0);
      check("halt_stays", 32'(halted), 32'd1);
    end
    npc_valid = 1'b0;
    imem_ack  = 1'b0;
    ir_ready  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("halt_async_clear", 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_halt_req", 32'(imem_req), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
